pulse_reg_mc: RTL and testbench
===============================

Name: pulse_reg_mc

Overview:
Multi-channel successor to the single-channel pulse parameter register. It decodes the pulse command word and buffers env/phase/freq/amp/cfg for N_CHAN pulse channels. Each channel has a shadow (staging) set and an active (output) set. Commits are explicit per channel or broadcast, and each field also has an accumulate mode. It sits between the processor command/register datapath and the per-channel pulse generators.

Parameters:
N_CHAN, 4, number of pulse channels (1..16)
DATA_WIDTH, 32, width of reg_in
ENV_WORD_WIDTH, 24, envelope word width
PHASE_WIDTH, 17, phase word width
FREQ_WIDTH, 9, frequency word width
AMP_WIDTH, 16, amplitude word width
CFG_WIDTH, 4, config word width
CHAN_W, max(1,$clog2(N_CHAN)), derived; channel-select width
CMD_W, ENV+PHASE+FREQ+AMP+CFG widths+9, derived; command width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pulse_cmd_in  in  CMD_W  layout MSB→LSB: |2b env_op|env|2b phase_op|phase|2b freq_op|freq|2b amp_op|amp|1b cfg_wen|cfg|
reg_in  in  DATA_WIDTH  processor register operand
chan_sel  in  CHAN_W  target channel
bcast_in  in  1  apply write/commit to all channels; chan_sel ignored
pulse_write_en  in  1  qualifies shadow update from pulse_cmd_in
cstrobe_in  in  1  commit shadow→active on target channel(s)
env_out  out  N_CHAN*ENV_WORD_WIDTH  active env per channel, ch0 in LSBs (same packing for all *_out)
phase_out  out  N_CHAN*PHASE_WIDTH  active phase
freq_out  out  N_CHAN*FREQ_WIDTH  active freq
amp_out  out  N_CHAN*AMP_WIDTH  active amp
cfg_out  out  N_CHAN*CFG_WIDTH  active cfg
cstrobe_out  out  N_CHAN  one-cycle commit strobe per channel
pending_out  out  N_CHAN  shadow differs in write history from active (written since last commit)
sel_err_out  out  1  one-cycle pulse: non-broadcast access with chan_sel >= N_CHAN

Behaviour:
- Reset: clears all shadow and active registers, cstrobe_out, pending_out and sel_err_out to 0. Reset dominates every concurrent write or commit.
- Field op, 2 bits per field:
  - 00: hold.
  - 10: load the cmd field.
  - 11: load reg_in[W-1:0].
  - 01: accumulate, shadow <= shadow + reg_in[W-1:0] mod 2^W (wraps, no saturation).
- cfg: cfg_wen=1 loads the cmd cfg field. cfg has no reg or accumulate option.
- Shadow update happens on the clk edge where pulse_write_en=1. Target is chan_sel, or every channel if bcast_in=1. With broadcast accumulate, each channel adds reg_in to its own shadow.
- Commit happens on the clk edge where cstrobe_in=1. The target channel's active set is loaded and cstrobe_out[ch] is high for exactly the following cycle. Latency cstrobe_in→outputs/cstrobe_out is 1 cycle. Non-target channels hold and their cstrobe_out stays 0.
- Simultaneous pulse_write_en and cstrobe_in, same channel: active loads the post-write (next-shadow) value, i.e. write forwards into the commit. pending is cleared.
- Simultaneous write to channel A and commit of channel B cannot occur: there is one chan_sel. A broadcast write with a non-broadcast commit is impossible because bcast_in applies to both.
- pending_out[ch]: set by any shadow write with at least one field enabled to ch. Cleared by a commit of ch; commit wins over a same-cycle write, per the forwarding rule.
- Commit with pending=0 is legal: it re-applies the current shadow and still pulses cstrobe_out.
- chan_sel >= N_CHAN with bcast_in=0 while write_en or cstrobe_in=1: no state change, sel_err_out=1 the next cycle.
- Active outputs are registered and change only on commit or reset.

Test Plan:
- Reset then idle → all *_out=0, cstrobe_out=0, pending_out=0. Assert reset mid-write: state stays 0 the next cycle.
- Ch2 write: amp_op=10 amp=0x1234, freq_op=11 reg_in=0x1FF. Then cstrobe_in with chan_sel=2 the next cycle. Required: amp_out[ch2]=0x1234 and freq_out[ch2]=0x1FF one cycle after the strobe, cstrobe_out=4'b0100 for one cycle, pending[2] 1→0. Other channels unchanged.
- Phase accumulate on ch0: load 0x1FFF0 (PHASE_WIDTH 17), then op=01 with reg_in=0x20, commit. Required: phase_out[ch0]=0x00010 (wrap).
- Same-cycle write of env=0xABCDEF and commit on ch1 → env_out[ch1]=0xABCDEF one cycle later, pending[1]=0.
- bcast_in=1, amp_op=01, reg_in=1, with shadows amp=5/6/7/8 on ch0..3, then broadcast commit. Required: amp_out=6/7/8/9 and cstrobe_out=4'b1111.
- With N_CHAN=3, chan_sel=3 plus write and cstrobe. Required: no output change, sel_err_out pulses for 1 cycle, cstrobe_out=0.

Source files
------------

// File: rtl/pulse_reg_mc.sv
// pulse_reg_mc
// Multi-channel pulse parameter register. Decodes the pulse command word and
// keeps a shadow (staging) and an active (output) copy of env/phase/freq/amp/cfg
// for each of N_CHAN pulse channels. Shadow fields can hold, load from the
// command word, load from the processor register operand, or accumulate the
// operand. A commit copies shadow to active on the selected channel, or on all
// channels when broadcasting.
//
// Ports:
//   clk            clock
//   reset          synchronous active-high reset, clears every register
//   pulse_cmd_in   command word |env_op|env|phase_op|phase|freq_op|freq|amp_op|amp|cfg_wen|cfg|
//   reg_in         processor register operand for load-from-reg and accumulate
//   chan_sel       target channel (ignored when bcast_in=1)
//   bcast_in       apply write and/or commit to every channel
//   pulse_write_en shadow update strobe
//   cstrobe_in     commit strobe (shadow -> active)
//   env_out .. cfg_out  active fields, channel 0 in the LSBs
//   cstrobe_out    per-channel one-cycle commit strobe
//   pending_out    per-channel "shadow written since last commit"
//   sel_err_out    one-cycle pulse after an access to a nonexistent channel
module pulse_reg_mc #(
    parameter int N_CHAN         = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ENV_WORD_WIDTH = 24,
    parameter int PHASE_WIDTH    = 17,
    parameter int FREQ_WIDTH     = 9,
    parameter int AMP_WIDTH      = 16,
    parameter int CFG_WIDTH      = 4,
    parameter int CHAN_W         = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
    parameter int CMD_W          = ENV_WORD_WIDTH + PHASE_WIDTH + FREQ_WIDTH
                                   + AMP_WIDTH + CFG_WIDTH + 9
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [CMD_W-1:0]                   pulse_cmd_in,
    input  logic [DATA_WIDTH-1:0]              reg_in,
    input  logic [CHAN_W-1:0]                  chan_sel,
    input  logic                               bcast_in,
    input  logic                               pulse_write_en,
    input  logic                               cstrobe_in,
    output logic [N_CHAN*ENV_WORD_WIDTH-1:0]   env_out,
    output logic [N_CHAN*PHASE_WIDTH-1:0]      phase_out,
    output logic [N_CHAN*FREQ_WIDTH-1:0]       freq_out,
    output logic [N_CHAN*AMP_WIDTH-1:0]        amp_out,
    output logic [N_CHAN*CFG_WIDTH-1:0]        cfg_out,
    output logic [N_CHAN-1:0]                  cstrobe_out,
    output logic [N_CHAN-1:0]                  pending_out,
    output logic                               sel_err_out
);

    // Bit positions of each field in the command word, built up from the LSB.
    localparam int CFG_LO   = 0;
    localparam int CFG_WEN  = CFG_LO + CFG_WIDTH;
    localparam int AMP_LO   = CFG_WEN + 1;
    localparam int AMP_OP   = AMP_LO + AMP_WIDTH;
    localparam int FREQ_LO  = AMP_OP + 2;
    localparam int FREQ_OP  = FREQ_LO + FREQ_WIDTH;
    localparam int PHASE_LO = FREQ_OP + 2;
    localparam int PHASE_OP = PHASE_LO + PHASE_WIDTH;
    localparam int ENV_LO   = PHASE_OP + 2;
    localparam int ENV_OP   = ENV_LO + ENV_WORD_WIDTH;

    logic [1:0]                env_op, phase_op, freq_op, amp_op;
    logic                      cfg_wen;
    logic [ENV_WORD_WIDTH-1:0] env_cmd;
    logic [PHASE_WIDTH-1:0]    phase_cmd;
    logic [FREQ_WIDTH-1:0]     freq_cmd;
    logic [AMP_WIDTH-1:0]      amp_cmd;
    logic [CFG_WIDTH-1:0]      cfg_cmd;
    logic [31:0]               reg_ext;
    logic [31:0]               sel_ext;
    logic                      sel_bad;
    logic                      any_en;
    logic [N_CHAN-1:0]         wr_hit, cm_hit;

    logic [ENV_WORD_WIDTH-1:0] env_sh   [N_CHAN], env_act   [N_CHAN], env_nx   [N_CHAN];
    logic [PHASE_WIDTH-1:0]    phase_sh [N_CHAN], phase_act [N_CHAN], phase_nx [N_CHAN];
    logic [FREQ_WIDTH-1:0]     freq_sh  [N_CHAN], freq_act  [N_CHAN], freq_nx  [N_CHAN];
    logic [AMP_WIDTH-1:0]      amp_sh   [N_CHAN], amp_act   [N_CHAN], amp_nx   [N_CHAN];
    logic [CFG_WIDTH-1:0]      cfg_sh   [N_CHAN], cfg_act   [N_CHAN], cfg_nx   [N_CHAN];

    // Field update rule, evaluated at 32 bits; callers truncate to the field
    // width, which gives the modulo-2^W wrap for accumulate.
    function automatic logic [31:0] apply_op(input logic [1:0]  op,
                                             input logic [31:0] cur,
                                             input logic [31:0] cmdv,
                                             input logic [31:0] regv);
        logic [31:0] res;
        case (op)
            2'b10:   res = cmdv;
            2'b11:   res = regv;
            2'b01:   res = cur + regv;
            default: res = cur;
        endcase
        return res;
    endfunction

    assign env_op    = pulse_cmd_in[ENV_OP +: 2];
    assign env_cmd   = pulse_cmd_in[ENV_LO +: ENV_WORD_WIDTH];
    assign phase_op  = pulse_cmd_in[PHASE_OP +: 2];
    assign phase_cmd = pulse_cmd_in[PHASE_LO +: PHASE_WIDTH];
    assign freq_op   = pulse_cmd_in[FREQ_OP +: 2];
    assign freq_cmd  = pulse_cmd_in[FREQ_LO +: FREQ_WIDTH];
    assign amp_op    = pulse_cmd_in[AMP_OP +: 2];
    assign amp_cmd   = pulse_cmd_in[AMP_LO +: AMP_WIDTH];
    assign cfg_wen   = pulse_cmd_in[CFG_WEN];
    assign cfg_cmd   = pulse_cmd_in[CFG_LO +: CFG_WIDTH];

    assign reg_ext = 32'(reg_in);
    assign sel_ext = 32'(chan_sel);
    assign sel_bad = !bcast_in && (sel_ext >= 32'(N_CHAN));
    assign any_en  = (env_op != 2'b00) || (phase_op != 2'b00) || (freq_op != 2'b00)
                     || (amp_op != 2'b00) || cfg_wen;

    // Per-channel targeting. An out-of-range chan_sel matches no channel, so a
    // bad access changes nothing and only raises sel_err_out.
    always_comb begin
        wr_hit = '0;
        cm_hit = '0;
        for (int ch = 0; ch < N_CHAN; ch++) begin
            wr_hit[ch] = pulse_write_en && (bcast_in || (sel_ext == 32'(ch)));
            cm_hit[ch] = cstrobe_in && (bcast_in || (sel_ext == 32'(ch)));
        end
    end

    // Candidate next shadow per channel; accumulate uses each channel's own shadow.
    always_comb begin
        for (int ch = 0; ch < N_CHAN; ch++) begin
            env_nx[ch]   = ENV_WORD_WIDTH'(apply_op(env_op, 32'(env_sh[ch]), 32'(env_cmd), reg_ext));
            phase_nx[ch] = PHASE_WIDTH'(apply_op(phase_op, 32'(phase_sh[ch]), 32'(phase_cmd), reg_ext));
            freq_nx[ch]  = FREQ_WIDTH'(apply_op(freq_op, 32'(freq_sh[ch]), 32'(freq_cmd), reg_ext));
            amp_nx[ch]   = AMP_WIDTH'(apply_op(amp_op, 32'(amp_sh[ch]), 32'(amp_cmd), reg_ext));
            cfg_nx[ch]   = cfg_wen ? cfg_cmd : cfg_sh[ch];
        end
    end

    // Shadow/active registers. A commit in the same cycle as a write takes the
    // post-write shadow, and the commit clears pending even though a write landed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < N_CHAN; ch++) begin
                env_sh[ch]    <= '0;
                phase_sh[ch]  <= '0;
                freq_sh[ch]   <= '0;
                amp_sh[ch]    <= '0;
                cfg_sh[ch]    <= '0;
                env_act[ch]   <= '0;
                phase_act[ch] <= '0;
                freq_act[ch]  <= '0;
                amp_act[ch]   <= '0;
                cfg_act[ch]   <= '0;
            end
            cstrobe_out <= '0;
            pending_out <= '0;
            sel_err_out <= 1'b0;
        end else begin
            for (int ch = 0; ch < N_CHAN; ch++) begin
                if (wr_hit[ch]) begin
                    env_sh[ch]   <= env_nx[ch];
                    phase_sh[ch] <= phase_nx[ch];
                    freq_sh[ch]  <= freq_nx[ch];
                    amp_sh[ch]   <= amp_nx[ch];
                    cfg_sh[ch]   <= cfg_nx[ch];
                end
                if (cm_hit[ch]) begin
                    env_act[ch]   <= wr_hit[ch] ? env_nx[ch]   : env_sh[ch];
                    phase_act[ch] <= wr_hit[ch] ? phase_nx[ch] : phase_sh[ch];
                    freq_act[ch]  <= wr_hit[ch] ? freq_nx[ch]  : freq_sh[ch];
                    amp_act[ch]   <= wr_hit[ch] ? amp_nx[ch]   : amp_sh[ch];
                    cfg_act[ch]   <= wr_hit[ch] ? cfg_nx[ch]   : cfg_sh[ch];
                end
                cstrobe_out[ch] <= cm_hit[ch];
                if (cm_hit[ch]) begin
                    pending_out[ch] <= 1'b0;
                end else if (wr_hit[ch] && any_en) begin
                    pending_out[ch] <= 1'b1;
                end
            end
            sel_err_out <= sel_bad && (pulse_write_en || cstrobe_in);
        end
    end

    // Pack the active sets onto the flat output buses, channel 0 in the LSBs.
    for (genvar g = 0; g < N_CHAN; g++) begin : g_pack
        assign env_out[g*ENV_WORD_WIDTH +: ENV_WORD_WIDTH] = env_act[g];
        assign phase_out[g*PHASE_WIDTH +: PHASE_WIDTH]     = phase_act[g];
        assign freq_out[g*FREQ_WIDTH +: FREQ_WIDTH]        = freq_act[g];
        assign amp_out[g*AMP_WIDTH +: AMP_WIDTH]           = amp_act[g];
        assign cfg_out[g*CFG_WIDTH +: CFG_WIDTH]           = cfg_act[g];
    end

endmodule

// File: tb/tb_pulse_reg_mc.sv
// tb_pulse_reg_mc
// Testbench for pulse_reg_mc. A 4-channel instance is driven with directed
// and random command sequences and compared each cycle against a per-channel
// field model; a 3-channel instance exercises out-of-range channel selects.
module tb_pulse_reg_mc;

    localparam int NC = 4;

    logic         clk;
    logic         reset;
    logic [78:0]  pulse_cmd_in;
    logic [31:0]  reg_in;
    logic [1:0]   chan_sel;
    logic         bcast_in;
    logic         pulse_write_en;
    logic         cstrobe_in;
    logic [95:0]  env_out;
    logic [67:0]  phase_out;
    logic [35:0]  freq_out;
    logic [63:0]  amp_out;
    logic [15:0]  cfg_out;
    logic [3:0]   cstrobe_out;
    logic [3:0]   pending_out;
    logic         sel_err_out;

    logic         r3;
    logic [78:0]  cmd3;
    logic [31:0]  reg3;
    logic [1:0]   sel3;
    logic         bc3, we3, cs3;
    logic [71:0]  env3;
    logic [50:0]  ph3;
    logic [26:0]  fr3;
    logic [47:0]  amp3;
    logic [11:0]  cfg3;
    logic [2:0]   cst3, pend3;
    logic         serr3;

    // Stimulus fields for the 4-channel instance
    logic [1:0]   e_op, p_op, f_op, a_op;
    logic [23:0]  e_v;
    logic [16:0]  p_v;
    logic [8:0]   f_v;
    logic [15:0]  a_v;
    logic         c_wen;
    logic [3:0]   c_v;
    logic [31:0]  rv;
    logic [1:0]   sel;
    logic         bc, we, cs, rst;

    // Reference model: field index 0..4 = env, phase, freq, amp, cfg
    int           wid [5] = '{24, 17, 9, 16, 4};
    longint       sh  [NC][5];
    longint       act [NC][5];
    logic [3:0]   pend;
    logic [3:0]   exp_cstr;
    logic         exp_selerr;

    int           total;
    int           bad;

    pulse_reg_mc dut (
        .clk(clk), .reset(reset), .pulse_cmd_in(pulse_cmd_in), .reg_in(reg_in),
        .chan_sel(chan_sel), .bcast_in(bcast_in), .pulse_write_en(pulse_write_en),
        .cstrobe_in(cstrobe_in), .env_out(env_out), .phase_out(phase_out),
        .freq_out(freq_out), .amp_out(amp_out), .cfg_out(cfg_out),
        .cstrobe_out(cstrobe_out), .pending_out(pending_out), .sel_err_out(sel_err_out)
    );

    pulse_reg_mc #(.N_CHAN(3)) dut3 (
        .clk(clk), .reset(r3), .pulse_cmd_in(cmd3), .reg_in(reg3),
        .chan_sel(sel3), .bcast_in(bc3), .pulse_write_en(we3),
        .cstrobe_in(cs3), .env_out(env3), .phase_out(ph3),
        .freq_out(fr3), .amp_out(amp3), .cfg_out(cfg3),
        .cstrobe_out(cst3), .pending_out(pend3), .sel_err_out(serr3)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    function automatic longint fieldOp(input logic [1:0] op, input longint cur,
                                       input longint cmdv, input longint regv, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        case (op)
            2'b10:   return cmdv & m;
            2'b11:   return regv & m;
            2'b01:   return (cur + regv) & m;
            default: return cur;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clearCmd();
        e_op = 0; p_op = 0; f_op = 0; a_op = 0; c_wen = 0;
        e_v = 0; p_v = 0; f_v = 0; a_v = 0; c_v = 0;
        rv = 0; sel = 0; bc = 0; we = 0; cs = 0; rst = 0;
    endtask

    // Advance the model by one clock edge using the currently applied inputs
    task automatic modelStep();
        logic [1:0] ops [5];
        longint     cmdv [5];
        longint     nxt [5];
        logic       any;
        if (rst) begin
            for (int c = 0; c < NC; c++)
                for (int f = 0; f < 5; f++) begin
                    sh[c][f] = 0;
                    act[c][f] = 0;
                end
            pend = 0; exp_cstr = 0; exp_selerr = 0;
        end else begin
            ops[0] = e_op; ops[1] = p_op; ops[2] = f_op; ops[3] = a_op;
            ops[4] = c_wen ? 2'b10 : 2'b00;
            cmdv[0] = e_v; cmdv[1] = p_v; cmdv[2] = f_v; cmdv[3] = a_v; cmdv[4] = c_v;
            any = (e_op != 0) || (p_op != 0) || (f_op != 0) || (a_op != 0) || c_wen;
            exp_cstr = 0;
            exp_selerr = !bc && (int'(sel) >= NC) && (we || cs);
            for (int c = 0; c < NC; c++) begin
                if (bc || int'(sel) == c) begin
                    for (int f = 0; f < 5; f++)
                        nxt[f] = fieldOp(ops[f], sh[c][f], cmdv[f], longint'(rv), wid[f]);
                    if (cs) begin
                        for (int f = 0; f < 5; f++)
                            act[c][f] = we ? nxt[f] : sh[c][f];
                        exp_cstr[c] = 1'b1;
                        pend[c] = 1'b0;
                    end
                    if (we) begin
                        for (int f = 0; f < 5; f++)
                            sh[c][f] = nxt[f];
                        if (any && !cs) pend[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [127:0] packField(input int f);
        logic [127:0] p;
        p = 0;
        for (int c = 0; c < NC; c++)
            p = p | (128'(act[c][f]) << (c * wid[f]));
        return p;
    endfunction

    // Drive one cycle of stimulus, update the model, then check every output
    task automatic applyStimulus();
        pulse_cmd_in   = {e_op, e_v, p_op, p_v, f_op, f_v, a_op, a_v, c_wen, c_v};
        reg_in         = rv;
        chan_sel       = sel;
        bcast_in       = bc;
        pulse_write_en = we;
        cstrobe_in     = cs;
        reset          = rst;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("env_out",     128'(env_out),     packField(0));
        checkOutput("phase_out",   128'(phase_out),   packField(1));
        checkOutput("freq_out",    128'(freq_out),    packField(2));
        checkOutput("amp_out",     128'(amp_out),     packField(3));
        checkOutput("cfg_out",     128'(cfg_out),     packField(4));
        checkOutput("cstrobe_out", 128'(cstrobe_out), 128'(exp_cstr));
        checkOutput("pending_out", 128'(pending_out), 128'(pend));
        checkOutput("sel_err_out", 128'(sel_err_out), 128'(exp_selerr));
    endtask

    initial begin
        total = 0; bad = 0;
        pend = 0; exp_cstr = 0; exp_selerr = 0;
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < 5; f++) begin
                sh[c][f] = 0;
                act[c][f] = 0;
            end
        r3 = 0; cmd3 = 0; reg3 = 0; sel3 = 0; bc3 = 0; we3 = 0; cs3 = 0;
        clearCmd();

        // Reset, then idle
        rst = 1; applyStimulus();
        clearCmd(); applyStimulus();

        // Reset while a broadcast write and commit are requested
        clearCmd(); rst = 1; bc = 1; we = 1; cs = 1; a_op = 2'b10; a_v = 16'hFFFF;
        e_op = 2'b11; rv = 32'hFFFF_FFFF; applyStimulus();
        checkOutput("reset_mid_write_amp", 128'(amp_out), 128'(0));

        // Channel 2: amp from command, freq from reg_in, then commit
        clearCmd(); sel = 2; we = 1; a_op = 2'b10; a_v = 16'h1234; f_op = 2'b11; rv = 32'h1FF;
        applyStimulus();
        checkOutput("ch2_pending_set", 128'(pending_out), 128'(4'b0100));
        clearCmd(); sel = 2; cs = 1; applyStimulus();
        checkOutput("ch2_amp", 128'(amp_out[47:32]), 128'(16'h1234));
        checkOutput("ch2_freq", 128'(freq_out[26:18]), 128'(9'h1FF));
        checkOutput("ch2_cstrobe", 128'(cstrobe_out), 128'(4'b0100));
        clearCmd(); applyStimulus();

        // Channel 0 phase accumulate wraps at 17 bits
        clearCmd(); sel = 0; we = 1; p_op = 2'b10; p_v = 17'h1FFF0; applyStimulus();
        clearCmd(); sel = 0; we = 1; p_op = 2'b01; rv = 32'h20; applyStimulus();
        clearCmd(); sel = 0; cs = 1; applyStimulus();
        checkOutput("ch0_phase_wrap", 128'(phase_out[16:0]), 128'(17'h00010));

        // Channel 1 write forwarded into a same-cycle commit
        clearCmd(); sel = 1; we = 1; cs = 1; e_op = 2'b10; e_v = 24'hABCDEF; applyStimulus();
        checkOutput("ch1_env_fwd", 128'(env_out[47:24]), 128'(24'hABCDEF));
        checkOutput("ch1_pending", 128'(pending_out[1]), 128'(1'b0));

        // Broadcast accumulate on per-channel shadows, then broadcast commit
        for (int c = 0; c < NC; c++) begin
            clearCmd(); sel = 2'(c); we = 1; a_op = 2'b10; a_v = 16'(5 + c); applyStimulus();
        end
        clearCmd(); bc = 1; we = 1; a_op = 2'b01; rv = 32'd1; applyStimulus();
        clearCmd(); bc = 1; cs = 1; applyStimulus();
        checkOutput("bcast_amp", 128'(amp_out), 128'({16'd9, 16'd8, 16'd7, 16'd6}));
        checkOutput("bcast_cstrobe", 128'(cstrobe_out), 128'(4'b1111));

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            clearCmd();
            e_op = 2'($urandom_range(0, 3)); e_v = 24'($urandom);
            p_op = 2'($urandom_range(0, 3)); p_v = 17'($urandom);
            f_op = 2'($urandom_range(0, 3)); f_v = 9'($urandom);
            a_op = 2'($urandom_range(0, 3)); a_v = 16'($urandom);
            c_wen = 1'($urandom_range(0, 1)); c_v = 4'($urandom);
            rv = $urandom;
            sel = 2'($urandom_range(0, 3));
            bc = ($urandom_range(0, 3) == 0);
            we = 1'($urandom_range(0, 1));
            cs = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 29) == 0);
            applyStimulus();
        end

        // Final reset with concurrent broadcast write and commit
        clearCmd(); rst = 1; bc = 1; we = 1; cs = 1; a_op = 2'b10; a_v = 16'hBEEF; applyStimulus();
        clearCmd(); applyStimulus();

        // Three-channel instance: out-of-range select
        r3 = 1; @(posedge clk); #1; r3 = 0;
        checkOutput("n3_reset_amp", 128'(amp3), 128'(0));
        checkOutput("n3_reset_serr", 128'(serr3), 128'(0));
        cmd3 = {2'b00, 24'h0, 2'b00, 17'h0, 2'b00, 9'h0, 2'b10, 16'h0055, 1'b0, 4'h0};
        sel3 = 1; we3 = 1; cs3 = 1;
        @(posedge clk); #1;
        checkOutput("n3_ch1_amp", 128'(amp3), 128'(48'h0000_0055_0000));
        checkOutput("n3_ch1_cstrobe", 128'(cst3), 128'(3'b010));
        cmd3 = {2'b00, 24'h0, 2'b00, 17'h0, 2'b00, 9'h0, 2'b10, 16'h0077, 1'b0, 4'h0};
        sel3 = 3; we3 = 1; cs3 = 1;
        @(posedge clk); #1;
        checkOutput("n3_bad_amp", 128'(amp3), 128'(48'h0000_0055_0000));
        checkOutput("n3_bad_cstrobe", 128'(cst3), 128'(3'b000));
        checkOutput("n3_bad_pending", 128'(pend3), 128'(3'b000));
        checkOutput("n3_bad_serr", 128'(serr3), 128'(1'b1));
        we3 = 0; cs3 = 0;
        @(posedge clk); #1;
        checkOutput("n3_serr_clear", 128'(serr3), 128'(1'b0));
        sel3 = 1; cs3 = 1;
        @(posedge clk); #1;
        cs3 = 0;
        checkOutput("n3_recommit_amp", 128'(amp3), 128'(48'h0000_0055_0000));
        checkOutput("n3_recommit_cstrobe", 128'(cst3), 128'(3'b010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
